// File: rtl/mono_rx_packet_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mono_rx_packet_arbiter_if                                                  |
// | Bus, channel-FIFO and downstream-FIFO signals of the rx packet arbiter.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface mono_rx_packet_arbiter_if #(
  parameter int ABUSWIDTH = 16,
  parameter int N_CH      = 4
);
  logic [ABUSWIDTH-1:0] BUS_ADD;
  logic [7:0]           BUS_DATA_IN;
  logic [7:0]           BUS_DATA_OUT;
  logic                 BUS_WR;
  logic                 BUS_RD;
  logic [N_CH-1:0]      CH_FIFO_EMPTY;
  logic [32*N_CH-1:0]   CH_FIFO_DATA;
  logic [N_CH-1:0]      CH_FIFO_READ;
  logic                 OUT_FIFO_FULL;
  logic                 OUT_WRITE;
  logic [31:0]          OUT_DATA;
  logic                 BUSY;

  // Arbiter side
  modport slave (
    input  BUS_ADD, BUS_DATA_IN, BUS_WR, BUS_RD,
    input  CH_FIFO_EMPTY, CH_FIFO_DATA, OUT_FIFO_FULL,
    output BUS_DATA_OUT, CH_FIFO_READ, OUT_WRITE, OUT_DATA, BUSY
  );

  // Bus master / FIFO environment side
  modport master (
    output BUS_ADD, BUS_DATA_IN, BUS_WR, BUS_RD,
    output CH_FIFO_EMPTY, CH_FIFO_DATA, OUT_FIFO_FULL,
    input  BUS_DATA_OUT, CH_FIFO_READ, OUT_WRITE, OUT_DATA, BUSY
  );
endinterface
`default_nettype wire

// File: rtl/mono_rx_packet_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mono_rx_packet_arbiter                                                     |
// | Round-robin merge of N_CH show-ahead rx word FIFOs into one downstream     |
// | FIFO, moving atomic PKT_WORDS-word packets, with a small basil register    |
// | file (enable mask, sync-error and packet counters).                        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module mono_rx_packet_arbiter #(
  parameter int ABUSWIDTH = 16,
  parameter int N_CH      = 4,
  parameter int PKT_WORDS = 3
) (
  input logic                     BUS_CLK,
  input logic                     RST,
  mono_rx_packet_arbiter_if.slave bus
);
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_XFER = 1'b1} state_t;

  localparam int c_gw  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int c_wcw = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam logic [c_wcw-1:0]     c_last_word = c_wcw'(PKT_WORDS - 1);
  localparam logic [c_gw-1:0]      c_last_ch   = c_gw'(N_CH - 1);
  localparam logic [7:0]           c_version   = 8'd1;
  localparam logic [ABUSWIDTH-1:0] c_addr_ver  = ABUSWIDTH'(0);
  localparam logic [ABUSWIDTH-1:0] c_addr_mask = ABUSWIDTH'(1);
  localparam logic [ABUSWIDTH-1:0] c_addr_serr = ABUSWIDTH'(2);
  localparam logic [ABUSWIDTH-1:0] c_addr_pklo = ABUSWIDTH'(3);
  localparam logic [ABUSWIDTH-1:0] c_addr_pkhi = ABUSWIDTH'(4);

  state_t           r_state;
  logic [c_gw-1:0]  r_grant;
  logic [c_gw-1:0]  r_last_grant;
  logic [c_wcw-1:0] r_word_cnt;
  logic [N_CH-1:0]  r_en_mask;
  logic [7:0]       r_sync_err_cnt;
  logic [15:0]      r_pkt_cnt;
  logic             r_busy;
  logic [7:0]       r_data_out;

  logic [31:0]      w_ch_data [N_CH];
  logic             w_soft_rst;
  logic             w_rst;
  logic [N_CH-1:0]  w_req;
  logic             w_found;
  logic [c_gw-1:0]  w_next_grant;
  logic [c_gw-1:0]  w_scan;
  logic             w_in_xfer;
  logic             w_g_empty;
  logic [31:0]      w_g_data;
  logic             w_sync_err;
  logic             w_xfer;
  logic [7:0]       w_mask_byte;
  logic [7:0]       w_rd_mux;
  logic             w_unused;

  for (genvar c = 0; c < N_CH; c++) begin : g_unpack
    assign w_ch_data[c] = bus.CH_FIFO_DATA[32*c +: 32];
  end

  // A write to address 0 resets everything on the same edge, like RST,
  // but does not gate the pop/write strobes of the cycle it occurs in.
  assign w_soft_rst = bus.BUS_WR && (bus.BUS_ADD == c_addr_ver);
  assign w_rst      = RST || w_soft_rst;
  assign w_req      = r_en_mask & ~bus.CH_FIFO_EMPTY;

  assign w_in_xfer  = (r_state == ST_XFER);
  assign w_g_empty  = bus.CH_FIFO_EMPTY[r_grant];
  assign w_g_data   = w_ch_data[r_grant];
  // A packet must start with bit27 clear; a continuation word at the head
  // is discarded without being forwarded.
  assign w_sync_err = w_in_xfer && (r_word_cnt == '0) && !w_g_empty && w_g_data[27];
  assign w_xfer     = w_in_xfer && !w_g_empty && !bus.OUT_FIFO_FULL && !w_sync_err;

  assign bus.OUT_WRITE    = w_xfer && !RST;
  assign bus.OUT_DATA     = w_g_data;
  assign bus.BUSY         = r_busy;
  assign bus.BUS_DATA_OUT = r_data_out;
  assign w_unused         = ^bus.BUS_DATA_IN;

  // Round-robin search starting just after the last channel served.
  always_comb begin
    w_found      = 1'b0;
    w_next_grant = r_grant;
    w_scan       = '0;
    for (int k = 1; k <= N_CH; k++) begin
      w_scan = c_gw'((int'(r_last_grant) + k) % N_CH);
      if (!w_found && w_req[w_scan]) begin
        w_found      = 1'b1;
        w_next_grant = w_scan;
      end
    end
  end

  // Pop strobe for the granted channel, on a transfer or a discarded sync word.
  always_comb begin
    bus.CH_FIFO_READ = '0;
    if ((w_xfer || w_sync_err) && !RST) begin
      bus.CH_FIFO_READ[r_grant] = 1'b1;
    end
  end

  // Register readback multiplexer.
  always_comb begin
    w_mask_byte             = '0;
    w_mask_byte[N_CH-1:0]   = r_en_mask;
    case (bus.BUS_ADD)
      c_addr_ver:  w_rd_mux = c_version;
      c_addr_mask: w_rd_mux = w_mask_byte;
      c_addr_serr: w_rd_mux = r_sync_err_cnt;
      c_addr_pklo: w_rd_mux = r_pkt_cnt[7:0];
      c_addr_pkhi: w_rd_mux = r_pkt_cnt[15:8];
      default:     w_rd_mux = 8'd0;
    endcase
  end

  // Arbitration FSM: pick a channel in IDLE, move one whole packet in XFER.
  always_ff @(posedge BUS_CLK) begin
    if (w_rst) begin
      r_state        <= ST_IDLE;
      r_grant        <= '0;
      r_last_grant   <= c_last_ch;
      r_word_cnt     <= '0;
      r_sync_err_cnt <= '0;
      r_pkt_cnt      <= '0;
      r_busy         <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant <= w_next_grant;
            r_state <= ST_XFER;
            r_busy  <= 1'b1;
          end
        end
        ST_XFER: begin
          if (w_sync_err && (r_sync_err_cnt != 8'hFF)) begin
            r_sync_err_cnt <= r_sync_err_cnt + 8'd1;
          end
          if (w_xfer) begin
            if (r_word_cnt == c_last_word) begin
              r_word_cnt   <= '0;
              r_last_grant <= r_grant;
              r_pkt_cnt    <= r_pkt_cnt + 16'd1;
              r_state      <= ST_IDLE;
              r_busy       <= 1'b0;
            end else begin
              r_word_cnt <= r_word_cnt + c_wcw'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Enable-mask write and registered read data.
  always_ff @(posedge BUS_CLK) begin
    if (w_rst) begin
      r_en_mask  <= '0;
      r_data_out <= '0;
    end else begin
      if (bus.BUS_WR && (bus.BUS_ADD == c_addr_mask)) begin
        r_en_mask <= bus.BUS_DATA_IN[N_CH-1:0];
      end
      if (bus.BUS_RD) begin
        r_data_out <= w_rd_mux;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mono_rx_packet_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mono_rx_packet_arbiter                                                  |
// | Directed bench: show-ahead channel FIFO models, a packet-level reference   |
// | model checked every cycle, and literal expectations per scenario.          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_mono_rx_packet_arbiter;
  localparam int NC = 4;
  localparam int PW = 3;
  localparam int AW = 16;

  logic BUS_CLK = 1'b0;
  logic RST     = 1'b1;
  always #5 BUS_CLK = ~BUS_CLK;

  mono_rx_packet_arbiter_if #(.ABUSWIDTH(AW), .N_CH(NC)) bus ();

  mono_rx_packet_arbiter #(.ABUSWIDTH(AW), .N_CH(NC), .PKT_WORDS(PW)) dut (
    .BUS_CLK (BUS_CLK),
    .RST     (RST),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int npops = 0;

  // Channel FIFOs: circular buffers, pushed by the stimulus, popped by the DUT.
  logic [31:0] fmem [NC][64];
  int          fwr  [NC] = '{default: 0};
  int          frd  [NC] = '{default: 0};
  logic        flush = 1'b0;

  logic [31:0] outq   [$];
  int          outcyc [$];

  always_comb begin
    bus.CH_FIFO_EMPTY = '1;
    bus.CH_FIFO_DATA  = '0;
    for (int c = 0; c < NC; c++) begin
      bus.CH_FIFO_EMPTY[c]          = (fwr[c] == frd[c]);
      bus.CH_FIFO_DATA[32*c +: 32]  = fmem[c][frd[c] & 63];
    end
  end

  // FIFO pops, flushes and the cycle counter.
  always @(posedge BUS_CLK) begin
    cyc   <= cyc + 1;
    npops <= npops + $countones(bus.CH_FIFO_READ);
    for (int c = 0; c < NC; c++) begin
      if (flush) frd[c] <= fwr[c];
      else if (bus.CH_FIFO_READ[c]) frd[c] <= frd[c] + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: packet-level view of which channel owns the output.
  bit          m_valid = 1'b0;
  bit          m_busy;
  int          m_g, m_cnt, m_last, m_serr, m_pkt, m_ch;
  logic [NC-1:0] m_mask;
  logic [7:0]  m_rd;
  bit          e_empty, e_serr, e_xf;
  logic [31:0] e_head;
  logic [NC-1:0] e_rd;

  always @(negedge BUS_CLK) begin
    if (m_valid) begin
      e_empty = (fwr[m_g] == frd[m_g]);
      e_head  = fmem[m_g][frd[m_g] & 63];
      e_serr  = m_busy && (m_cnt == 0) && !e_empty && e_head[27];
      e_xf    = m_busy && !e_empty && !bus.OUT_FIFO_FULL && !e_serr;
      e_rd    = '0;
      if (!RST && (e_xf || e_serr)) e_rd[m_g] = 1'b1;
      chk("busy",         bus.BUSY,         m_busy);
      chk("out_write",    bus.OUT_WRITE,    e_xf && !RST);
      chk("ch_fifo_read", bus.CH_FIFO_READ, e_rd);
      chk("bus_data_out", bus.BUS_DATA_OUT, m_rd);
      if (e_xf && !RST) chk("out_data", bus.OUT_DATA, e_head);
    end
    if (bus.OUT_WRITE) begin
      outq.push_back(bus.OUT_DATA);
      outcyc.push_back(cyc);
    end
    if (RST || (bus.BUS_WR && bus.BUS_ADD == 16'd0)) begin
      m_valid = 1'b1; m_busy = 1'b0; m_g = 0; m_cnt = 0; m_last = NC - 1;
      m_mask = '0; m_serr = 0; m_pkt = 0; m_rd = 8'd0;
    end else if (m_valid) begin
      if (bus.BUS_RD) begin
        case (bus.BUS_ADD)
          16'd0:   m_rd = 8'd1;
          16'd1:   m_rd = 8'(m_mask);
          16'd2:   m_rd = 8'(m_serr);
          16'd3:   m_rd = 8'(m_pkt % 256);
          16'd4:   m_rd = 8'(m_pkt / 256);
          default: m_rd = 8'd0;
        endcase
      end
      if (m_busy) begin
        if (e_serr && m_serr < 255) m_serr = m_serr + 1;
        if (e_xf) begin
          if (m_cnt == PW - 1) begin
            m_cnt = 0; m_last = m_g; m_pkt = (m_pkt + 1) % 65536; m_busy = 1'b0;
          end else begin
            m_cnt = m_cnt + 1;
          end
        end
      end else begin
        for (int k = 1; k <= NC; k++) begin
          m_ch = (m_last + k) % NC;
          if (!m_busy && m_mask[m_ch] && (fwr[m_ch] != frd[m_ch])) begin
            m_g = m_ch; m_busy = 1'b1;
          end
        end
      end
      if (bus.BUS_WR && bus.BUS_ADD == 16'd1) m_mask = bus.BUS_DATA_IN[NC-1:0];
    end
  end

  function automatic logic [31:0] pw(input int ch, input int n, input int k);
    return {4'h0, (k != 0), 3'h0, 8'(ch), 8'(n), 8'(k)};
  endfunction

  task automatic tick();
    @(posedge BUS_CLK); #1;
  endtask

  task automatic push(input int c, input logic [31:0] w);
    fmem[c][fwr[c] & 63] = w;
    fwr[c] = fwr[c] + 1;
  endtask

  task automatic push_pkt(input int c, input int n);
    for (int k = 0; k < PW; k++) push(c, pw(c, n, k));
  endtask

  task automatic bus_write(input int a, input int d);
    bus.BUS_ADD = AW'(a); bus.BUS_DATA_IN = 8'(d); bus.BUS_WR = 1'b1;
    tick();
    bus.BUS_WR = 1'b0; bus.BUS_ADD = 16'hFFFF;
  endtask

  task automatic bus_read(input int a, input int exp, input string nm);
    bus.BUS_ADD = AW'(a); bus.BUS_RD = 1'b1;
    tick();
    bus.BUS_RD = 1'b0; bus.BUS_ADD = 16'hFFFF;
    chk(nm, bus.BUS_DATA_OUT, exp);
  endtask

  task automatic do_reset();
    RST = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    RST = 1'b0;
    outq.delete(); outcyc.delete();
  endtask

  task automatic wait_words(input int n, input int lim, input string nm);
    int t = 0;
    while (outq.size() < n && t < lim) begin tick(); t++; end
    chk(nm, outq.size() >= n, 1);
  endtask

  int en_edge, np;
  int exp_ch [5] = '{0, 1, 2, 3, 0};
  int exp_n  [5] = '{1, 1, 1, 1, 2};

  initial begin
    bus.BUS_ADD = 16'hFFFF; bus.BUS_DATA_IN = 8'd0; bus.BUS_WR = 1'b0;
    bus.BUS_RD = 1'b0; bus.OUT_FIFO_FULL = 1'b0;
    do_reset();
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_out_write", bus.OUT_WRITE, 0);
    chk("rst_data_out", bus.BUS_DATA_OUT, 0);
    bus_read(1, 0, "rst_mask");
    bus_read(0, 1, "version");

    // 1: two packets on channel 0
    push_pkt(0, 1); push_pkt(0, 2);
    bus_write(1, 1);
    en_edge = cyc;
    wait_words(6, 60, "t1_wait");
    for (int i = 0; i < 6; i++) chk("t1_word", outq[i], pw(0, 1 + i / 3, i % 3));
    chk("t1_first_write_edge", outcyc[0] + 1 - en_edge, 2);
    chk("t1_bubble", outcyc[3] - outcyc[2], 2);
    chk("t1_contig", outcyc[2] - outcyc[0], 2);
    tick();
    bus_read(3, 2, "t1_pkt_lo");
    bus_read(4, 0, "t1_pkt_hi");

    // 2: round robin over four channels, then refill channel 0
    do_reset();
    for (int c = 0; c < NC; c++) push_pkt(c, 1);
    bus_write(1, 15);
    wait_words(6, 60, "t2_wait_a");
    push_pkt(0, 2);
    wait_words(15, 100, "t2_wait_b");
    for (int p = 0; p < 5; p++)
      for (int k = 0; k < PW; k++) chk("t2_word", outq[3*p + k], pw(exp_ch[p], exp_n[p], k));

    // 3: downstream full for five cycles after the first word
    do_reset();
    push_pkt(1, 3);
    bus_write(1, 2);
    wait_words(1, 40, "t3_wait_a");
    bus.OUT_FIFO_FULL = 1'b1;
    np = npops;
    repeat (5) tick();
    bus.OUT_FIFO_FULL = 1'b0;
    chk("t3_no_write", outq.size(), 1);
    chk("t3_no_pop", npops - np, 0);
    chk("t3_grant_held", bus.BUSY, 1);
    tick();
    chk("t3_resume", outq.size(), 2);
    wait_words(3, 20, "t3_wait_b");
    for (int k = 0; k < PW; k++) chk("t3_word", outq[k], pw(1, 3, k));

    // 4: continuation word at the head of a channel
    do_reset();
    push(0, 32'h1C00_0005); push_pkt(0, 4);
    np = npops;
    bus_write(1, 1);
    wait_words(3, 40, "t4_wait");
    for (int k = 0; k < PW; k++) chk("t4_word", outq[k], pw(0, 4, k));
    tick();
    chk("t4_pops", npops - np, 4);
    bus_read(2, 1, "t4_sync_err");
    bus_read(3, 1, "t4_pkt_lo");

    // 5: hard reset after the first word of a packet
    push_pkt(2, 5);
    bus_write(1, 4);
    wait_words(4, 40, "t5_wait");
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("t5_busy", bus.BUSY, 0);
    bus_read(2, 0, "t5_sync_err");
    bus_read(3, 0, "t5_pkt_lo");
    bus_read(1, 0, "t5_mask");
    np = npops;
    repeat (10) tick();
    chk("t5_no_pop", npops - np, 0);
    chk("t5_fifo_left", fwr[2] - frd[2], 2);

    // 6: disabling the channel mid-packet
    do_reset();
    push_pkt(2, 6);
    bus_write(1, 4);
    wait_words(1, 40, "t6_wait_a");
    bus_write(1, 0);
    wait_words(3, 40, "t6_wait_b");
    push_pkt(2, 7);
    repeat (10) tick();
    chk("t6_words", outq.size(), 3);
    for (int k = 0; k < PW; k++) chk("t6_word", outq[k], pw(2, 6, k));
    chk("t6_idle", bus.BUSY, 0);
    chk("t6_fifo_left", fwr[2] - frd[2], 3);
    bus_read(3, 1, "t6_pkt_lo");

    // 7: soft reset clears the register file
    bus_write(1, 3);
    bus_read(1, 3, "t7_mask");
    bus_write(0, 0);
    bus_read(1, 0, "t7_mask_cleared");
    bus_read(3, 0, "t7_pkt_cleared");
    bus_read(7, 0, "t7_unmapped");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1);
  end
endmodule
`default_nettype wire
